// File: rtl/wb_async_mem_pkg.sv
// Shared definitions for the async-memory to Wishbone posted bridge.
// FSM encoding and the read pattern returned on a failed access.
package wb_async_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_RETRY = 2'd3;

  localparam logic [63:0] RD_ERR_PAT = '1;

endpackage

// File: rtl/wb_async_mem_sync.sv
// Multi-flop synchroniser for a bus of asynchronous inputs.
// Each bit is synchronised independently; reset value is per bit.
module wb_async_mem_sync #(
  parameter int              WIDTH   = 1,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= RST_VAL;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wb_async_mem_wfifo.sv
// Posted-write FIFO with wrap-bit pointers.
// A pop in the same cycle frees room for a push into a full FIFO.
module wb_async_mem_wfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PW-1] != r_rd[PW-1]) &&
                   (r_wr[IW-1:0] == r_rd[IW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rd[IW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[IW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/wb_async_mem_posted_bridge.sv
// Async SRAM-style slave to Wishbone classic master bridge with
// posted writes, retry/timeout handling and sticky error flags.
module wb_async_mem_posted_bridge
  import wb_async_mem_pkg::*;
#(
  parameter int  DW          = 32,
  parameter int  AW          = 32,
  parameter int  SYNC_STAGES = 2,
  parameter int  WF_DEPTH    = 4,
  parameter int  MAX_RETRY   = 3,
  parameter int  TIMEOUT     = 255,
  localparam int SW          = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] wb_data_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  inout  wire  [DW-1:0] mem_d,
  input  logic [AW-1:0] mem_a,
  input  logic [SW-1:0] mem_bls_n,
  input  logic          mem_oe_n,
  input  logic          mem_we_n,
  input  logic          mem_cs_n,
  output logic          mem_wait_n,
  output logic          err_o,
  output logic          ovf_o,
  input  logic          err_clr_i
);

  localparam int EW  = AW + DW + SW;
  localparam int IW  = 3 + SW + AW + DW;
  localparam int RCW = $clog2(MAX_RETRY + 2);
  localparam int TW  = $clog2(TIMEOUT + 2);
  localparam logic [IW-1:0] SYNC_RST =
    {3'b111, {SW{1'b1}}, {(AW+DW){1'b0}}};

  logic [IW-1:0] w_sync;
  logic          w_cs_n, w_oe_n, w_we_n;
  logic [SW-1:0] w_bls_n;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;

  wb_async_mem_sync #(
    .WIDTH   (IW),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_d     ({mem_cs_n, mem_oe_n, mem_we_n,
               mem_bls_n, mem_a, mem_d}),
    .o_q     (w_sync)
  );

  assign {w_cs_n, w_oe_n, w_we_n, w_bls_n, w_a, w_d} = w_sync;

  logic [1:0]     r_state;
  logic           r_cyc, r_stb, r_we;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_data;
  logic [SW-1:0]  r_sel;
  logic           r_we_q, r_oe_q;
  logic [AW-1:0]  r_a_q;
  logic [DW-1:0]  r_d_q;
  logic [SW-1:0]  r_bls_q;
  logic           r_rd_pend, r_rd_valid;
  logic [AW-1:0]  r_rd_addr;
  logic [SW-1:0]  r_rd_sel;
  logic [DW-1:0]  r_rd_data;
  logic           r_err, r_ovf, r_wait_n, r_ret_wr;
  logic [RCW-1:0] r_rty_cnt;
  logic [TW-1:0]  r_tmo;

  logic          w_push, w_pop, w_full, w_empty;
  logic [EW-1:0] w_head;
  logic          w_we_rise, w_oe_fall, w_oe_rise;
  logic          w_busy, w_rty_max, w_tmo_hit;
  logic          w_ack, w_fail, w_retry, w_ovf;

  // Captured address/data are the previous synced values, stable at the edge
  assign w_we_rise = w_we_n & ~r_we_q & ~w_cs_n;
  assign w_oe_fall = ~w_oe_n & r_oe_q & ~w_cs_n;
  assign w_oe_rise = w_oe_n & ~r_oe_q;

  assign w_busy    = (r_state == ST_WR) | (r_state == ST_RD);
  assign w_rty_max = (r_rty_cnt == RCW'(MAX_RETRY));
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT));
  assign w_ack     = w_busy & wb_ack_i;
  assign w_retry   = w_busy & ~wb_ack_i & ~wb_err_i &
                     wb_rty_i & ~w_rty_max;
  assign w_fail    = w_busy & ~wb_ack_i &
                     (wb_err_i | (wb_rty_i & w_rty_max) |
                      (~wb_rty_i & w_tmo_hit));

  assign w_push = w_we_rise;
  assign w_pop  = (r_state == ST_WR) & (w_ack | w_fail);
  assign w_ovf  = w_push & w_full & ~w_pop;

  wb_async_mem_wfifo #(
    .WIDTH (EW),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_push  (w_push),
    .i_wdata ({r_a_q, r_d_q, ~r_bls_q}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state    <= ST_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_sel      <= '0;
      r_we_q     <= 1'b1;
      r_oe_q     <= 1'b1;
      r_a_q      <= '0;
      r_d_q      <= '0;
      r_bls_q    <= '1;
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_sel   <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_wait_n   <= 1'b1;
      r_ret_wr   <= 1'b0;
      r_rty_cnt  <= '0;
      r_tmo      <= '0;
    end else begin
      r_we_q   <= w_we_n;
      r_oe_q   <= w_oe_n;
      r_a_q    <= w_a;
      r_d_q    <= w_d;
      r_bls_q  <= w_bls_n;
      r_wait_n <= ~(r_rd_pend | w_full);
      r_err    <= (r_err & ~err_clr_i) | w_fail;
      r_ovf    <= (r_ovf & ~err_clr_i) | w_ovf;
      if (w_oe_rise) r_rd_valid <= 1'b0;
      if (w_oe_fall) begin
        r_rd_pend  <= 1'b1;
        r_rd_valid <= 1'b0;
        r_rd_addr  <= r_a_q;
        r_rd_sel   <= ~r_bls_q;
      end
      unique case (r_state)
        ST_IDLE: begin
          // Drain posted writes before servicing a read
          if (!w_empty) begin
            r_state   <= ST_WR;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_we      <= 1'b1;
            r_addr    <= w_head[EW-1 -: AW];
            r_data    <= w_head[SW +: DW];
            r_sel     <= w_head[SW-1:0];
            r_rty_cnt <= '0;
            r_tmo     <= '0;
          end else if (r_rd_pend) begin
            r_state   <= ST_RD;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= r_rd_addr;
            r_sel     <= r_rd_sel;
            r_rty_cnt <= '0;
            r_tmo     <= '0;
          end
        end
        ST_WR, ST_RD: begin
          if (w_ack | w_fail) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            if (r_state == ST_RD) begin
              r_rd_data  <= w_ack ? wb_data_i
                                  : RD_ERR_PAT[DW-1:0];
              r_rd_valid <= 1'b1;
              r_rd_pend  <= 1'b0;
            end
          end else if (w_retry) begin
            r_state   <= ST_RETRY;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_ret_wr  <= (r_state == ST_WR);
            r_rty_cnt <= r_rty_cnt + RCW'(1);
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_RETRY: begin
          r_state <= r_ret_wr ? ST_WR : ST_RD;
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= r_ret_wr;
          r_tmo   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_d = (~w_cs_n & ~w_oe_n & r_rd_valid)
               ? r_rd_data : {DW{1'bz}};

  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_addr_o  = r_addr;
  assign wb_data_o  = r_data;
  assign wb_sel_o   = r_sel;
  assign mem_wait_n = r_wait_n;
  assign err_o      = r_err;
  assign ovf_o      = r_ovf;

endmodule
